regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file; next generation of the core's 2R/1W regfile.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 36 +++
 rtl/regfile_mp.sv | 67 ++++++
 tb/tb_regfile_mp.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, typedefs and constants for the multi-port register file
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   xlen_t / reg_addr_t  : default-sized data word and register address
//   ZERO_ADDR            : address of the hardwired-zero register
package regfile_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   typedef logic [XLEN_DEF-1:0]          xlen_t;
   typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
   localparam reg_addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy flags for RAW hazard detection
//   clk, rstn  : clock, async active-low reset
//   write_reg  : NWR packed write addresses; write_en : per-port write strobe (releases busy)
//   rsv_reg    : register to reserve; rsv_en : reserve strobe (sets busy)
//   busy       : NREGS busy flags
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NREGS    = NREGS_DEF,
   parameter  int NWR      = 1,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(NREGS)
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic [NWR*AW-1:0] write_reg,
   input  logic [NWR-1:0]    write_en,
   input  logic [AW-1:0]     rsv_reg,
   input  logic              rsv_en,
   output logic [NREGS-1:0]  busy
);
   localparam logic [AW-1:0] ZA = AW'(ZERO_ADDR);
   logic [NREGS-1:0] busy_nxt;
   // Releases are applied before the reserve so a new producer issued in the
   // same cycle as the old one's writeback keeps the register busy.
   always_comb begin
      busy_nxt = busy;
      for (int j = 0; j < NWR; j++)
         if (write_en[j]) busy_nxt[write_reg[j*AW +: AW]] = 1'b0;
      if (rsv_en) busy_nxt[rsv_reg] = 1'b1;
      if (ZERO_REG != 0) busy_nxt[ZA] = 1'b0;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) busy <= '0;
      else       busy <= busy_nxt;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with optional x0 and write->read bypass
//   clk, rstn   : clock, async active-low reset
//   read_reg    : NRD packed read addresses; read_data : NRD packed read words
//   read_busy   : per read port, addressed register has an outstanding reservation
//   write_reg / write_data / write_en : NWR packed write ports, higher index wins
//   rsv_reg / rsv_en : reserve a register (mark busy)
//   busy_any    : any register busy
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int XLEN     = XLEN_DEF,
   parameter  int NREGS    = NREGS_DEF,
   parameter  int NRD      = 2,
   parameter  int NWR      = 1,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int AW       = $clog2(NREGS)
)(
   input  logic                clk,
   input  logic                rstn,
   input  logic [NRD*AW-1:0]   read_reg,
   output logic [NRD*XLEN-1:0] read_data,
   output logic [NRD-1:0]      read_busy,
   input  logic [NWR*AW-1:0]   write_reg,
   input  logic [NWR*XLEN-1:0] write_data,
   input  logic [NWR-1:0]      write_en,
   input  logic [AW-1:0]       rsv_reg,
   input  logic                rsv_en,
   output logic                busy_any
);
   localparam logic [AW-1:0] ZA = AW'(ZERO_ADDR);
   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   // Ascending port order makes the highest-index port the last assignment, so it wins.
   always_ff @(posedge clk or negedge rstn)
      if (!rstn)
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      else
         for (int j = 0; j < NWR; j++)
            if (write_en[j] && !(ZERO_REG != 0 && write_reg[j*AW +: AW] == ZA))
               regs[write_reg[j*AW +: AW]] <= write_data[j*XLEN +: XLEN];
   regfile_scoreboard #(.NREGS(NREGS), .NWR(NWR), .ZERO_REG(ZERO_REG)) u_sb (
      .clk       (clk),
      .rstn      (rstn),
      .write_reg (write_reg),
      .write_en  (write_en),
      .rsv_reg   (rsv_reg),
      .rsv_en    (rsv_en),
      .busy      (busy)
   );
   assign busy_any = |busy;
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] d;
      assign ra = read_reg[i*AW +: AW];
      // Reset gating matters only for the bypass path: storage already reads 0 in reset.
      always_comb begin
         d = regs[ra];
         if (BYPASS != 0)
            for (int j = 0; j < NWR; j++)
               if (write_en[j] && write_reg[j*AW +: AW] == ra) d = write_data[j*XLEN +: XLEN];
         if (!rstn || (ZERO_REG != 0 && ra == ZA)) d = '0;
      end
      assign read_data[i*XLEN +: XLEN] = d;
      assign read_busy[i] = busy[ra];
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed self-checking bench for regfile_mp
module tb_regfile_mp;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [4:0]  rreg [2];
   logic [4:0]  wreg [2];
   logic [31:0] wdata [2];
   logic [1:0]  wen;
   logic [4:0]  rsv_reg;
   logic        rsv_en;
   logic [63:0] rd;
   logic [1:0]  rbusy;
   logic        bany;
   logic [31:0] rd_nb;
   logic [0:0]  rbusy_nb;
   logic        bany_nb;
   logic [31:0] m [32];
   logic [31:0] mnb [32];
   logic        mb [32];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   regfile_mp #(.NRD(2), .NWR(2)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .read_reg   ({rreg[1], rreg[0]}),
      .read_data  (rd),
      .read_busy  (rbusy),
      .write_reg  ({wreg[1], wreg[0]}),
      .write_data ({wdata[1], wdata[0]}),
      .write_en   (wen),
      .rsv_reg    (rsv_reg),
      .rsv_en     (rsv_en),
      .busy_any   (bany)
   );

   regfile_mp #(.NRD(1), .NWR(1), .BYPASS(0)) dut_nb (
      .clk        (clk),
      .rstn       (rstn),
      .read_reg   (rreg[0]),
      .read_data  (rd_nb),
      .read_busy  (rbusy_nb),
      .write_reg  (wreg[0]),
      .write_data (wdata[0]),
      .write_en   (wen[0:0]),
      .rsv_reg    (rsv_reg),
      .rsv_en     (rsv_en),
      .busy_any   (bany_nb)
   );

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      logic [31:0] v;
      if (a == 0) return 32'd0;
      v = m[a];
      for (int j = 0; j < 2; j++) if (wen[j] && wreg[j] == a) v = wdata[j];
      return v;
   endfunction

   function automatic logic exp_any();
      logic r = 1'b0;
      for (int k = 0; k < 32; k++) r |= mb[k];
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 32; k++) begin m[k] = '0; mnb[k] = '0; mb[k] = 1'b0; end
   endtask

   task automatic tick();
      for (int j = 0; j < 2; j++) if (wen[j] && wreg[j] != 0) m[wreg[j]] = wdata[j];
      if (wen[0] && wreg[0] != 0) mnb[wreg[0]] = wdata[0];
      for (int j = 0; j < 2; j++) if (wen[j]) mb[wreg[j]] = 1'b0;
      if (rsv_en && rsv_reg != 0) mb[rsv_reg] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wen = '0; rsv_en = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      wreg[0] = 10; wdata[0] = 32'd12983; wen = 2'b01; rsv_en = 1'b1; rsv_reg = 4;
      tick();
      idle(); rreg[0] = 10; rreg[1] = 4; #1;
      n_tests++; if (rd[31:0] !== 32'd12983) begin n_fail++; $display("FAIL pre_reset_x10 got %0d want 12983", rd[31:0]); end
      n_tests++; if (bany !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy got %b want 1", bany); end
      wen = 2'b01; wdata[0] = 32'd55; rstn = 1'b0; #1;
      model_clear();
      n_tests++; if (rd[31:0] !== 32'd0) begin n_fail++; $display("FAIL reset_x10 got %0d want 0", rd[31:0]); end
      n_tests++; if (bany !== 1'b0) begin n_fail++; $display("FAIL reset_busy_any got %b want 0", bany); end
      n_tests++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL reset_read_busy got %b want 00", rbusy); end
      @(posedge clk); #1;
      n_tests++; if (rd[31:0] !== 32'd0) begin n_fail++; $display("FAIL reset_held_x10 got %0d want 0", rd[31:0]); end
      idle(); rstn = 1'b1;
      tick();
      n_tests++; if (rd[31:0] !== 32'd0) begin n_fail++; $display("FAIL post_reset_x10 got %0d want 0", rd[31:0]); end
   endtask

   task automatic test_basic();
      idle(); wreg[0] = 10; wdata[0] = 32'd12983; wen = 2'b01; tick();
      idle(); wreg[1] = 30; wdata[1] = 32'd324;   wen = 2'b10; tick();
      idle(); rreg[0] = 10; rreg[1] = 30; #1;
      n_tests++; if (rd[31:0] !== 32'd12983) begin n_fail++; $display("FAIL basic_x10 got %0d want 12983", rd[31:0]); end
      n_tests++; if (rd[63:32] !== 32'd324) begin n_fail++; $display("FAIL basic_x30 got %0d want 324", rd[63:32]); end
   endtask

   task automatic test_zero();
      idle(); wreg[0] = 0; wdata[0] = 32'd500; wen = 2'b01; rreg[0] = 0; #1;
      n_tests++; if (rd[31:0] !== 32'd0) begin n_fail++; $display("FAIL zero_bypass got %0d want 0", rd[31:0]); end
      tick(); idle(); #1;
      n_tests++; if (rd[31:0] !== 32'd0) begin n_fail++; $display("FAIL zero_stored got %0d want 0", rd[31:0]); end
      n_tests++; if (rd_nb !== 32'd0) begin n_fail++; $display("FAIL zero_stored_nb got %0d want 0", rd_nb); end
      rsv_en = 1'b1; rsv_reg = 0; tick(); idle(); #1;
      n_tests++; if (bany !== 1'b0) begin n_fail++; $display("FAIL zero_rsv_busy_any got %b want 0", bany); end
      n_tests++; if (rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL zero_rsv_read_busy got %b want 0", rbusy[0]); end
   endtask

   task automatic test_bypass();
      idle(); wreg[0] = 5; wdata[0] = -32'sd7; wen = 2'b01; rreg[0] = 5; #1;
      n_tests++; if (rd[31:0] !== -32'sd7) begin n_fail++; $display("FAIL bypass_x5 got %0d want -7", $signed(rd[31:0])); end
      n_tests++; if (rd_nb !== 32'd0) begin n_fail++; $display("FAIL nobypass_x5_old got %0d want 0", $signed(rd_nb)); end
      tick(); idle(); #1;
      n_tests++; if (rd_nb !== -32'sd7) begin n_fail++; $display("FAIL nobypass_x5_new got %0d want -7", $signed(rd_nb)); end
      n_tests++; if (rd[31:0] !== -32'sd7) begin n_fail++; $display("FAIL bypass_x5_stored got %0d want -7", $signed(rd[31:0])); end
   endtask

   task automatic test_dual();
      idle(); wreg[0] = 8; wreg[1] = 8; wdata[0] = 32'd1; wdata[1] = 32'd2; wen = 2'b11;
      rreg[0] = 8; rreg[1] = 8; #1;
      n_tests++; if (rd[63:32] !== 32'd2) begin n_fail++; $display("FAIL dual_bypass got %0d want 2", rd[63:32]); end
      tick(); idle(); #1;
      n_tests++; if (rd[31:0] !== 32'd2) begin n_fail++; $display("FAIL dual_stored got %0d want 2", rd[31:0]); end
   endtask

   task automatic test_scoreboard();
      idle(); rreg[0] = 3; rsv_en = 1'b1; rsv_reg = 3; #1;
      n_tests++; if (rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_before_edge got %b want 0", rbusy[0]); end
      tick(); idle(); #1;
      n_tests++; if (rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_reserved got %b want 1", rbusy[0]); end
      wreg[0] = 3; wdata[0] = 32'd9; wen = 2'b01; #1;
      n_tests++; if (rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_write_no_mask got %b want 1", rbusy[0]); end
      tick(); idle(); #1;
      n_tests++; if (rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_released got %b want 0", rbusy[0]); end
      n_tests++; if (rd[31:0] !== 32'd9) begin n_fail++; $display("FAIL sb_x3_data got %0d want 9", rd[31:0]); end
      wreg[0] = 3; wdata[0] = 32'd11; wen = 2'b01; rsv_en = 1'b1; rsv_reg = 3;
      tick(); idle(); #1;
      n_tests++; if (rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_rsv_wins got %b want 1", rbusy[0]); end
      n_tests++; if (bany !== 1'b1) begin n_fail++; $display("FAIL sb_busy_any got %b want 1", bany); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         for (int j = 0; j < 2; j++) begin
            rreg[j]  = 5'($urandom_range(0, 31));
            wreg[j]  = 5'($urandom_range(0, 7));
            wdata[j] = $urandom;
         end
         wen = 2'($urandom);
         rsv_en = 1'($urandom);
         rsv_reg = 5'($urandom_range(0, 7));
         if (c % 4 == 0) rreg[0] = wreg[0];
         if (c % 5 == 0) rreg[1] = wreg[1];
         #1;
         for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (rd[i*32 +: 32] !== exp_rd(rreg[i])) begin
               n_fail++; $display("FAIL rand_rd%0d cyc %0d x%0d got %h want %h", i, c, rreg[i], rd[i*32 +: 32], exp_rd(rreg[i]));
            end
            n_tests++;
            if (rbusy[i] !== (rreg[i] != 0 && mb[rreg[i]])) begin
               n_fail++; $display("FAIL rand_busy%0d cyc %0d x%0d got %b want %b", i, c, rreg[i], rbusy[i], rreg[i] != 0 && mb[rreg[i]]);
            end
         end
         n_tests++;
         if (rd_nb !== (rreg[0] == 0 ? 32'd0 : mnb[rreg[0]])) begin
            n_fail++; $display("FAIL rand_nb cyc %0d x%0d got %h want %h", c, rreg[0], rd_nb, rreg[0] == 0 ? 32'd0 : mnb[rreg[0]]);
         end
         n_tests++;
         if (bany !== exp_any()) begin
            n_fail++; $display("FAIL rand_busy_any cyc %0d got %b want %b", c, bany, exp_any());
         end
         tick();
      end
      idle();
   endtask

   initial begin
      for (int j = 0; j < 2; j++) begin rreg[j] = '0; wreg[j] = '0; wdata[j] = '0; end
      rsv_reg = '0;
      idle();
      model_clear();
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_zero();
      test_bypass();
      test_dual();
      test_scoreboard();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
